// File: rtl/board_mem_arbiter.sv
`default_nettype none
// ============================================================================
// Module      : board_mem_arbiter
// Description : Owns the single-port cell memory that holds both 10x10 boards
//               (own = board 0, enemy = board 1). It shares the memory between
//               three requesters, which are served in this order:
//                 1. video reads (fixed top priority, no grant signal)
//                 2. the pending write of a shot read-modify-write
//                 3. the full-board clear sweep
//                 4. game FSM and remote link, round-robin between the two
//               Optional ship counter: define BOARD_MEM_SHIP_COUNT_EN.
// Revision    : 1.0 - initial release
// ============================================================================
module board_mem_arbiter #(
  parameter int ROWS   = 10,
  parameter int COLS   = 10,
  parameter int DATA_W = 2
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              v_req,
  input  logic [8:0]        v_addr,
  output logic [DATA_W-1:0] v_rdata,
  output logic              v_rvalid,
  input  logic              g_req,
  input  logic              g_we,
  input  logic [8:0]        g_addr,
  input  logic [DATA_W-1:0] g_wdata,
  output logic              g_gnt,
  output logic [DATA_W-1:0] g_rdata,
  output logic              g_rvalid,
  input  logic              r_req,
  input  logic              r_we,
  input  logic              r_shot,
  input  logic [8:0]        r_addr,
  input  logic [DATA_W-1:0] r_wdata,
  output logic              r_gnt,
  output logic [DATA_W-1:0] r_rdata,
  output logic              r_rvalid,
  input  logic              clr,
`ifdef BOARD_MEM_SHIP_COUNT_EN
  output logic              busy,
  output logic [6:0]        ships_left,
  output logic              all_sunk
`else
  output logic              busy
`endif
);

  localparam int              c_DEPTH     = 512;
  localparam logic [8:0]      c_LAST_ADDR = 9'd511;
  localparam logic [DATA_W-1:0] c_EMPTY   = DATA_W'(0);
  localparam logic [DATA_W-1:0] c_SHIP    = DATA_W'(1);
  localparam logic [DATA_W-1:0] c_MISS    = DATA_W'(2);
  localparam logic [DATA_W-1:0] c_HIT     = DATA_W'(3);

  typedef enum logic [0:0] {
    ST_IDLE    = 1'b0,
    ST_SHOT_WR = 1'b1
  } state_t;

  // Address decode: {board, row[3:0], col[3:0]}; rows/cols past the board edge
  // are out of range for the game and remote requesters.
  function automatic logic f_oor(input logic [7:0] a);
    return (int'(a[7:4]) >= ROWS) || (int'(a[3:0]) >= COLS);
  endfunction

  logic [DATA_W-1:0] r_mem [0:c_DEPTH-1];
  logic [DATA_W-1:0] r_rd_raw;

  state_t            r_state;
  state_t            w_state_nxt;

  logic              r_shot_first;
  logic [DATA_W-1:0] r_shot_old;
  logic [8:0]        r_shot_addr;
  logic              r_shot_oor;
  logic [DATA_W-1:0] w_shot_old;
  logic [DATA_W-1:0] w_shot_new;
  logic              w_shot_need;

  logic              r_busy;
  logic [8:0]        r_sweep_addr;
  logic              w_sweep_start;
  logic              r_rr_prefer_g;

  logic              r_v_rvalid;
  logic              r_g_rvalid;
  logic              r_r_rvalid;
  logic              r_g_oor_q;
  logic              r_r_oor_q;

  logic              w_g_oor;
  logic              w_r_oor;
  logic              w_v_issue;
  logic              w_shot_issue;
  logic              w_sweep_issue;
  logic [8:0]        w_mem_addr;
  logic              w_mem_we;
  logic [DATA_W-1:0] w_mem_wdata;

  assign w_g_oor       = f_oor(g_addr[7:0]);
  assign w_r_oor       = f_oor(r_addr[7:0]);
  // A new sweep is accepted only when none is running; a pending shot write
  // still wins the slot, so the sweep naturally starts after it.
  assign w_sweep_start = clr && !r_busy;

  // Shot write value: SHIP becomes HIT, EMPTY becomes MISS, MISS/HIT need no write.
  // The old cell is taken straight from the read port in the first SHOT_WR cycle
  // and from the captured copy if video deferred the write.
  always_comb begin
    w_shot_old  = r_shot_first ? r_rd_raw : r_shot_old;
    w_shot_new  = w_shot_old;
    w_shot_need = 1'b0;
    if ((r_state == ST_SHOT_WR) && !r_shot_oor) begin
      if (w_shot_old == c_SHIP) begin
        w_shot_new  = c_HIT;
        w_shot_need = 1'b1;
      end else if (w_shot_old == c_EMPTY) begin
        w_shot_new  = c_MISS;
        w_shot_need = 1'b1;
      end
    end
  end

  // Slot arbitration: pick the single memory access issued this cycle.
  always_comb begin
    w_mem_addr    = 9'd0;
    w_mem_we      = 1'b0;
    w_mem_wdata   = c_EMPTY;
    w_v_issue     = 1'b0;
    w_shot_issue  = 1'b0;
    w_sweep_issue = 1'b0;
    g_gnt         = 1'b0;
    r_gnt         = 1'b0;
    if (v_req) begin
      w_v_issue  = 1'b1;
      w_mem_addr = v_addr;
    end else if (w_shot_need) begin
      w_shot_issue = 1'b1;
      w_mem_addr   = r_shot_addr;
      w_mem_we     = 1'b1;
      w_mem_wdata  = w_shot_new;
    end else if (r_busy) begin
      w_sweep_issue = 1'b1;
      w_mem_addr    = r_sweep_addr;
      w_mem_we      = 1'b1;
      w_mem_wdata   = c_EMPTY;
    end else if (g_req && (!r_req || r_rr_prefer_g)) begin
      g_gnt       = 1'b1;
      w_mem_addr  = g_addr;
      w_mem_we    = g_we && !w_g_oor;
      w_mem_wdata = g_wdata;
    end else if (r_req) begin
      r_gnt       = 1'b1;
      w_mem_addr  = r_addr;
      w_mem_we    = r_we && !r_shot && !w_r_oor;
      w_mem_wdata = r_wdata;
    end
  end

  // Single-port memory with registered (read-before-write) output; not reset.
  always_ff @(posedge clk) begin
    if (w_mem_we) begin
      r_mem[w_mem_addr] <= w_mem_wdata;
    end
    r_rd_raw <= r_mem[w_mem_addr];
  end

  // Shot state register.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      r_state <= ST_IDLE;
    end else begin
      r_state <= w_state_nxt;
    end
  end

  // Shot next state: leave SHOT_WR once the write issues or none is needed.
  always_comb begin
    w_state_nxt = r_state;
    if (r_gnt && r_shot) begin
      w_state_nxt = ST_SHOT_WR;
    end else if ((r_state == ST_SHOT_WR) && (!w_shot_need || w_shot_issue)) begin
      w_state_nxt = ST_IDLE;
    end
  end

  // Capture shot address/range at grant and hold the old cell across deferral.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      r_shot_first <= 1'b0;
      r_shot_old   <= c_EMPTY;
      r_shot_addr  <= 9'd0;
      r_shot_oor   <= 1'b0;
    end else begin
      r_shot_first <= r_gnt && r_shot;
      r_shot_old   <= w_shot_old;
      if (r_gnt && r_shot) begin
        r_shot_addr <= r_addr;
        r_shot_oor  <= w_r_oor;
      end
    end
  end

  // Clear sweep sequencer; reset release starts a sweep from address 0.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      r_busy       <= 1'b1;
      r_sweep_addr <= 9'd0;
    end else if (w_sweep_issue) begin
      r_sweep_addr <= r_sweep_addr + 9'd1;
      if (r_sweep_addr == c_LAST_ADDR) begin
        r_busy <= 1'b0;
      end
    end else if (w_sweep_start) begin
      r_busy       <= 1'b1;
      r_sweep_addr <= 9'd0;
    end
  end

  // Round-robin pointer moves only when G or R is actually granted.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      r_rr_prefer_g <= 1'b1;
    end else if (g_gnt) begin
      r_rr_prefer_g <= 1'b0;
    end else if (r_gnt) begin
      r_rr_prefer_g <= 1'b1;
    end
  end

  // Read-return tracking: who owns the data on the read port next cycle.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      r_v_rvalid <= 1'b0;
      r_g_rvalid <= 1'b0;
      r_r_rvalid <= 1'b0;
      r_g_oor_q  <= 1'b0;
      r_r_oor_q  <= 1'b0;
    end else begin
      r_v_rvalid <= w_v_issue;
      r_g_rvalid <= g_gnt && !g_we;
      r_r_rvalid <= r_gnt && (r_shot || !r_we);
      r_g_oor_q  <= w_g_oor;
      r_r_oor_q  <= w_r_oor;
    end
  end

  assign busy     = r_busy;
  assign v_rvalid = r_v_rvalid;
  assign g_rvalid = r_g_rvalid;
  assign r_rvalid = r_r_rvalid;
  // Data is forced to EMPTY when not valid, and for out-of-range G/R accesses.
  assign v_rdata  = r_v_rvalid ? r_rd_raw : c_EMPTY;
  assign g_rdata  = (r_g_rvalid && !r_g_oor_q) ? r_rd_raw : c_EMPTY;
  assign r_rdata  = (r_r_rvalid && !r_r_oor_q) ? r_rd_raw : c_EMPTY;

`ifdef BOARD_MEM_SHIP_COUNT_EN
  logic w_ship_inc;
  logic w_ship_dec;

  assign w_ship_inc = g_gnt && g_we && !w_g_oor && !g_addr[8] && (g_wdata == c_SHIP);
  assign w_ship_dec = w_shot_issue && !r_shot_addr[8] && (w_shot_old == c_SHIP);

  // Own-board ship tally, saturating, cleared at each sweep start.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      ships_left <= 7'd0;
      all_sunk   <= 1'b0;
    end else if (w_sweep_start) begin
      ships_left <= 7'd0;
      all_sunk   <= 1'b0;
    end else if (w_ship_inc) begin
      if (ships_left != 7'd127) begin
        ships_left <= ships_left + 7'd1;
      end
      all_sunk <= 1'b0;
    end else if (w_ship_dec && (ships_left != 7'd0)) begin
      ships_left <= ships_left - 7'd1;
      if (ships_left == 7'd1) begin
        all_sunk <= 1'b1;
      end
    end
  end
`endif

endmodule
`default_nettype wire

// File: tb/tb_board_mem_arbiter.sv
`default_nettype none
// ============================================================================
// Module      : tb_board_mem_arbiter
// Description : Directed self-checking bench for board_mem_arbiter.
// Revision    : 1.0 - initial release
// ============================================================================
module tb_board_mem_arbiter;

  logic       clk = 1'b0;
  logic       rst;
  logic       v_req, g_req, g_we, r_req, r_we, r_shot, clr;
  logic [8:0] v_addr, g_addr, r_addr;
  logic [1:0] g_wdata, r_wdata;
  logic [1:0] v_rdata, g_rdata, r_rdata;
  logic       v_rvalid, g_gnt, g_rvalid, r_gnt, r_rvalid, busy;
`ifdef BOARD_MEM_SHIP_COUNT_EN
  logic [6:0] ships_left;
  logic       all_sunk;
`endif

  int n_chk  = 0;
  int n_pass = 0;

  always #5 clk = ~clk;

  board_mem_arbiter dut (
    .clk      (clk),
    .rst      (rst),
    .v_req    (v_req),
    .v_addr   (v_addr),
    .v_rdata  (v_rdata),
    .v_rvalid (v_rvalid),
    .g_req    (g_req),
    .g_we     (g_we),
    .g_addr   (g_addr),
    .g_wdata  (g_wdata),
    .g_gnt    (g_gnt),
    .g_rdata  (g_rdata),
    .g_rvalid (g_rvalid),
    .r_req    (r_req),
    .r_we     (r_we),
    .r_shot   (r_shot),
    .r_addr   (r_addr),
    .r_wdata  (r_wdata),
    .r_gnt    (r_gnt),
    .r_rdata  (r_rdata),
    .r_rvalid (r_rvalid),
    .clr      (clr),
`ifdef BOARD_MEM_SHIP_COUNT_EN
    .busy       (busy),
    .ships_left (ships_left),
    .all_sunk   (all_sunk)
`else
    .busy     (busy)
`endif
  );

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_chk++;
    if (obs === exp) n_pass++;
    else $display("FAIL %s: got %0d expected %0d", tag, obs, exp);
  endtask

  // Issue one G access; returns just after the edge following the grant.
  task automatic g_access(input logic we, input logic [8:0] a, input logic [1:0] wd,
                          output logic [1:0] rd, output logic rv, output logic ok);
    @(negedge clk);
    g_req = 1'b1; g_we = we; g_addr = a; g_wdata = wd; ok = 1'b0;
    for (int i = 0; i < 1000; i++) begin
      #1;
      if (g_gnt) begin ok = 1'b1; break; end
      @(negedge clk);
    end
    if (ok) begin @(posedge clk); #1; end
    g_req = 1'b0; g_we = 1'b0;
    rd = g_rdata; rv = g_rvalid;
  endtask

  task automatic r_access(input logic we, input logic shot, input logic [8:0] a,
                          input logic [1:0] wd, output logic [1:0] rd,
                          output logic rv, output logic ok);
    @(negedge clk);
    r_req = 1'b1; r_we = we; r_shot = shot; r_addr = a; r_wdata = wd; ok = 1'b0;
    for (int i = 0; i < 1000; i++) begin
      #1;
      if (r_gnt) begin ok = 1'b1; break; end
      @(negedge clk);
    end
    if (ok) begin @(posedge clk); #1; end
    r_req = 1'b0; r_we = 1'b0; r_shot = 1'b0;
    rd = r_rdata; rv = r_rvalid;
  endtask

  task automatic g_write(input logic [8:0] a, input logic [1:0] d, input string tag);
    logic [1:0] rd; logic rv, ok;
    g_access(1'b1, a, d, rd, rv, ok);
    chk({tag, "_gnt"}, ok, 1);
    chk({tag, "_norv"}, rv, 0);
  endtask

  task automatic g_read(input logic [8:0] a, input logic [1:0] exp, input string tag);
    logic [1:0] rd; logic rv, ok;
    g_access(1'b0, a, 2'd0, rd, rv, ok);
    chk({tag, "_gnt"}, ok, 1);
    chk({tag, "_rv"}, rv, 1);
    chk({tag, "_rd"}, rd, exp);
  endtask

  task automatic r_op(input logic we, input logic shot, input logic [8:0] a,
                      input logic [1:0] wd, input logic [1:0] exp, input string tag);
    logic [1:0] rd; logic rv, ok;
    r_access(we, shot, a, wd, rd, rv, ok);
    chk({tag, "_gnt"}, ok, 1);
    chk({tag, "_rv"}, rv, !we || shot);
    if (!we || shot) chk({tag, "_rd"}, rd, exp);
  endtask

  task automatic v_read(input logic [8:0] a, input logic [1:0] exp, input string tag);
    @(negedge clk);
    v_req = 1'b1; v_addr = a;
    @(negedge clk);
    v_req = 1'b0;
    chk({tag, "_vrv"}, v_rvalid, 1);
    chk({tag, "_vrd"}, v_rdata, exp);
  endtask

  // Counts negedge samples with busy high, starting at the current negedge.
  // At sample poke_at: a clr, a G request and a video read are injected.
  task automatic count_busy(input int poke_at, output int cnt);
    cnt = 0;
    for (int i = 0; i < 2000; i++) begin
      if (!busy) break;
      cnt++;
      if (cnt == poke_at) begin
        clr = 1'b1; g_req = 1'b1; g_we = 1'b0; g_addr = 9'h000;
        v_req = 1'b1; v_addr = 9'h000;
        #1 chk("sweep_g_blocked", g_gnt, 0);
      end else begin
        if (cnt == poke_at + 1) chk("sweep_v_rvalid", v_rvalid, 1);
        clr = 1'b0; g_req = 1'b0; v_req = 1'b0;
      end
      @(negedge clk);
    end
  endtask

  initial begin
    int cnt;
    rst = 1'b0; clr = 1'b0;
    v_req = 1'b0; v_addr = 9'd0;
    g_req = 1'b0; g_we = 1'b0; g_addr = 9'd0; g_wdata = 2'd0;
    r_req = 1'b0; r_we = 1'b0; r_shot = 1'b0; r_addr = 9'd0; r_wdata = 2'd0;

    // Reset values
    repeat (3) @(negedge clk);
    chk("rst_busy", busy, 1);
    chk("rst_v_rvalid", v_rvalid, 0);
    chk("rst_g_rvalid", g_rvalid, 0);
    chk("rst_r_rvalid", r_rvalid, 0);
    chk("rst_g_rdata", g_rdata, 0);
    chk("rst_r_rdata", r_rdata, 0);
`ifdef BOARD_MEM_SHIP_COUNT_EN
    chk("rst_ships", ships_left, 0);
    chk("rst_sunk", all_sunk, 0);
`endif

    // Automatic sweep after release: exactly 512 busy cycles
    rst = 1'b1;
    count_busy(-1, cnt);
    chk("init_sweep_len", cnt, 512);
    g_read(9'h000, 2'd0, "zero_000");
    g_read(9'h199, 2'd0, "zero_199");
    v_read(9'h1FF, 2'd0, "zero_1ff");

    // Write / read / shot sequence on {0,3,4}
    g_write(9'h034, 2'd1, "w034");
    r_op(1'b0, 1'b0, 9'h034, 2'd0, 2'd1, "r034");
    r_op(1'b0, 1'b1, 9'h034, 2'd0, 2'd1, "shot1");
    g_read(9'h034, 2'd3, "after_shot1");
    r_op(1'b0, 1'b1, 9'h034, 2'd0, 2'd3, "shot2");
    g_read(9'h034, 2'd3, "after_shot2");

    // Round robin: last grant is R, so G is favoured first
    g_write(9'h011, 2'd1, "w011");
    r_op(1'b1, 1'b0, 9'h022, 2'd2, 2'd0, "rw022");
    @(negedge clk);
    g_req = 1'b1; g_we = 1'b0; g_addr = 9'h011;
    r_req = 1'b1; r_we = 1'b0; r_shot = 1'b0; r_addr = 9'h022;
    for (int k = 0; k < 4; k++) begin
      #1;
      chk("rr_g_gnt", g_gnt, (k % 2) == 0);
      chk("rr_r_gnt", r_gnt, (k % 2) == 1);
      if (k > 0) begin
        chk("rr_g_rvalid", g_rvalid, (k % 2) == 1);
        chk("rr_r_rvalid", r_rvalid, (k % 2) == 0);
        if ((k % 2) == 1) chk("rr_g_rdata", g_rdata, 1);
        else              chk("rr_r_rdata", r_rdata, 2);
      end
      @(negedge clk);
    end
    g_req = 1'b0; r_req = 1'b0;
    #1;
    chk("rr_last_r_rvalid", r_rvalid, 1);
    chk("rr_last_r_rdata", r_rdata, 2);
    chk("rr_idle_g_gnt", g_gnt, 0);

    // Video held during a shot defers the write and blocks G
    g_write(9'h045, 2'd1, "w045");
    @(negedge clk);
    r_req = 1'b1; r_shot = 1'b1; r_addr = 9'h045;
    #1 chk("vd_r_gnt", r_gnt, 1);
    @(negedge clk);
    r_req = 1'b0; r_shot = 1'b0;
    v_req = 1'b1; v_addr = 9'h011;
    g_req = 1'b1; g_we = 1'b0; g_addr = 9'h045;
    #1;
    chk("vd_r_rvalid", r_rvalid, 1);
    chk("vd_r_rdata", r_rdata, 1);
    chk("vd_g_blk1", g_gnt, 0);
    @(negedge clk);
    #1;
    chk("vd_v_rvalid", v_rvalid, 1);
    chk("vd_v_rdata", v_rdata, 1);
    chk("vd_g_blk2", g_gnt, 0);
    @(negedge clk);
    v_req = 1'b0;
    #1 chk("vd_g_blk_shotwr", g_gnt, 0);
    @(negedge clk);
    #1 chk("vd_g_gnt", g_gnt, 1);
    @(negedge clk);
    g_req = 1'b0;
    #1;
    chk("vd_g_rvalid", g_rvalid, 1);
    chk("vd_g_rdata", g_rdata, 3);

    // Out-of-range addresses: granted, writes suppressed, reads EMPTY
    g_write(9'h0A2, 2'd1, "oor_row_w");
    g_read(9'h0A2, 2'd0, "oor_row_r");
    v_read(9'h0A2, 2'd0, "oor_row_mem");
    g_write(9'h03A, 2'd1, "oor_col_w");
    v_read(9'h03A, 2'd0, "oor_col_mem");
    r_op(1'b0, 1'b1, 9'h0A2, 2'd0, 2'd0, "oor_shot");
    v_read(9'h0A2, 2'd0, "oor_shot_mem");

    // clr sweep; a clr mid-sweep is ignored and one video read steals a slot
    @(negedge clk); clr = 1'b1;
    @(negedge clk); clr = 1'b0;
    count_busy(200, cnt);
    chk("clr_sweep_len", cnt, 513);
    g_read(9'h045, 2'd0, "clr_045");
    g_read(9'h034, 2'd0, "clr_034");

`ifdef BOARD_MEM_SHIP_COUNT_EN
    g_write(9'h011, 2'd1, "sc_w1");
    chk("sc_ships1", ships_left, 1);
    g_write(9'h022, 2'd1, "sc_w2");
    g_write(9'h133, 2'd1, "sc_w_enemy");
    g_write(9'h033, 2'd1, "sc_w3");
    chk("sc_ships3", ships_left, 3);
    r_op(1'b0, 1'b1, 9'h011, 2'd0, 2'd1, "sc_shot1");
    @(posedge clk); #1;
    chk("sc_ships_a", ships_left, 2);
    r_op(1'b0, 1'b1, 9'h022, 2'd0, 2'd1, "sc_shot2");
    @(posedge clk); #1;
    chk("sc_ships_b", ships_left, 1);
    chk("sc_sunk_b", all_sunk, 0);
    r_op(1'b0, 1'b1, 9'h033, 2'd0, 2'd1, "sc_shot3");
    @(posedge clk); #1;
    chk("sc_ships_c", ships_left, 0);
    chk("sc_sunk_c", all_sunk, 1);
    @(negedge clk); clr = 1'b1;
    @(negedge clk); clr = 1'b0;
    chk("sc_clr_sunk", all_sunk, 0);
    chk("sc_clr_ships", ships_left, 0);
    count_busy(-1, cnt);
    chk("sc_sweep_len", cnt, 512);
`endif

    // Reset in the middle of a sweep restarts it from address 0
    g_write(9'h077, 2'd1, "pre_rst_w");
    @(negedge clk); clr = 1'b1;
    @(negedge clk); clr = 1'b0;
    repeat (50) @(negedge clk);
    rst = 1'b0;
    @(negedge clk);
    chk("mid_rst_busy", busy, 1);
    @(negedge clk);
    rst = 1'b1;
    count_busy(-1, cnt);
    chk("mid_rst_sweep_len", cnt, 512);
    v_read(9'h077, 2'd0, "mid_rst_077");

    $display("%0d/%0d checks passed", n_pass, n_chk);
    $finish;
  end

endmodule
`default_nettype wire

// File: doc/board_mem_arbiter.md
Name: board_mem_arbiter

Overview:
- Owns the single-port cell memory holding both 10x10 boards (own, enemy); BRAM-style, synchronous read.
- Shares the memory between three requesters:
  - video renderer (read-only, fixed top priority);
  - local game FSM (read/write);
  - remote-link handler (read/write plus atomic shot read-modify-write).
- Also sequences full-board clear sweeps. Sits between game control, the VGA draw path and the link receiver.

Parameters:
- ROWS, 10, valid rows per board; row index >= ROWS is out of range.
- COLS, 10, valid columns per board.
- DATA_W, 2, cell width. Codes: 0 EMPTY, 1 SHIP, 2 MISS, 3 HIT.

Ports:
- clk  in  1  system clock
- rst  in  1  asynchronous, active-low reset
- v_req  in  1  video read request
- v_addr  in  9  {board, row[3:0], col[3:0]}; board 0 = own
- v_rdata  out  2  video read data
- v_rvalid  out  1  v_rdata valid
- g_req / g_we  in  1 / 1  game request / write enable
- g_addr  in  9  game address
- g_wdata  in  2  game write data
- g_gnt  out  1  game grant pulse
- g_rdata / g_rvalid  out  2 / 1  game read data / valid
- r_req / r_we / r_shot  in  1 / 1 / 1  remote request / write / shot RMW (r_shot overrides r_we)
- r_addr  in  9  remote address
- r_wdata  in  2  remote write data
- r_gnt  out  1  remote grant pulse
- r_rdata / r_rvalid  out  2 / 1  remote read data or shot result (old cell) / valid
- clr  in  1  start clear sweep (pulse)
- busy  out  1  clear sweep in progress

Behaviour:
- Reset values:
  - all gnt/rvalid = 0; all rdata = 0; busy = 1; RR pointer favours G.
  - Memory contents are not reset.
  - On reset release an automatic clear sweep starts.
- One memory access per cycle. Priority, highest first:
  1. video;
  2. pending shot write;
  3. clear sweep;
  4. round-robin between G and R.
- Video:
  - v_req always serviced in the cycle it is asserted.
  - v_rvalid high and v_rdata valid the next cycle.
  - No grant signal.
- G/R handshake:
  - Requester holds req and its address/data stable until gnt.
  - gnt is a 1-cycle pulse in the cycle the access is issued.
  - Read: rvalid/rdata follow 1 cycle after gnt.
  - Write: takes effect at gnt; no rvalid.
  - Requester may drop req in the gnt cycle or re-request back-to-back.
- Round robin:
  - If both G and R request, grant the one not served last.
  - A single requester is granted whenever the slot is free.
  - The pointer updates only on a grant.
- Shot RMW (r_shot=1):
  - State machine: IDLE -> SHOT_WR -> IDLE.
  - At r_gnt (cycle T) the read is issued. r_rvalid/r_rdata = old cell at T+1.
  - SHOT_WR writes the new value: SHIP -> HIT; EMPTY -> MISS; MISS or HIT unchanged (no write).
  - The write is issued at T+1, or the first later cycle without v_req.
  - G/R grants and sweep are blocked until the write issues (atomic).
- Clear sweep:
  - Triggered by clr while busy=0, or by reset release.
  - Writes EMPTY to addresses 0..511, one per free slot, in ascending order.
  - busy drops the cycle after address 511 is written.
  - Video stays serviced and preempts sweep slots. G/R receive no grants while busy.
  - clr while busy: ignored, no restart.
  - clr while a shot write is pending: the sweep starts after that write.
  - Reset mid-sweep: abort, then a new sweep from address 0 on release.
- Out-of-range address (row >= ROWS or col >= COLS), G/R only:
  - Still granted.
  - Writes suppressed; reads and shot results return EMPTY.
  - Shot on out-of-range performs no write.

Optional Feature:
- Macro BOARD_MEM_SHIP_COUNT_EN.
- With the macro, extra outputs:
  - ships_left (7 bits, reset 0);
  - all_sunk (1 bit, reset 0).
- ships_left updates:
  - +1 on a granted in-range G write of SHIP to board 0;
  - -1 on a shot write SHIP -> HIT on board 0;
  - cleared to 0 when a sweep starts;
  - saturates at 0 and 127.
- all_sunk = 1 when ships_left returns to 0 after having been nonzero since the last sweep start.
- Without the macro, these ports and all related logic are absent.

Test Plan:
- Reset release, no requests -> busy=1 for exactly 512 cycles; reading any cell afterwards returns 0.
- g_req and r_req both held, reading different cells -> gnt alternates G,R,G,R starting with G; each rvalid 1 cycle after its gnt.
- Cell {0,3,4}=SHIP; r_shot at addr 0x034 -> r_rdata=1; later read returns 3. Repeat the shot -> r_rdata=3, cell stays 3.
- v_req held continuously during a shot -> shot write deferred; g_req ungranted until v_req drops. Then shot write, then g_gnt.
- G write SHIP to addr 0x0A2 (row 10) -> g_gnt=1; read-back returns 0.
- With BOARD_MEM_SHIP_COUNT_EN: place 3 ships, fire 3 shots on them -> ships_left 3,2,1,0; all_sunk=1. Then clr -> all_sunk=0.
